mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive D grants tolerated while I is pending.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: watchdog limit; used only under MEM_ARB_TIMEOUT_EN.
REQ-003 Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 I_valid  in  1  fetch read request; I_addr  in  32  fetch address.
REQ-006 I_done  out  1  fetch complete pulse; I_rdata  out  32  fetch data.
REQ-007 D_valid  in  1  data request; D_we  in  1  write when high; D_be  in  4  byte enables; D_addr  in  32; D_wdata  in  32.
REQ-008 D_done  out  1  data complete pulse; D_rdata  out  32  load data.
REQ-009 Mem_req  out  1; Mem_we  out  1; Mem_be  out  4; Mem_addr  out  32; Mem_wdata  out  32  shared memory port.
REQ-010 Mem_ack  in  1  memory completion; Mem_rdata  in  32  valid with Mem_ack.
REQ-011 Err  out  1  timeout pulse (tied 0 without MEM_ARB_TIMEOUT_EN).

Function
REQ-012 FSM states SHALL be IDLE, I_BUSY, D_BUSY; exactly one outstanding memory transaction.
REQ-013 In IDLE, D_valid only -> D_BUSY; I_valid only -> I_BUSY; neither -> stay IDLE.
REQ-014 Both valid in IDLE -> D_BUSY, unless starve count == STARVE_LIMIT, then I_BUSY.
REQ-015 Starve count: +1 on each D grant with I_valid high; cleared on I grant or I_valid low; saturates at STARVE_LIMIT.
REQ-016 On grant edge, Mem_req=1 and Mem_addr/we/be/wdata SHALL register the winner's fields (I: we=0, be=4'hF, wdata=0); held stable until ack.
REQ-017 In BUSY with Mem_ack=1 at edge: Mem_req->0, state->IDLE, winner's done=1 for exactly one cycle, winner's rdata registers Mem_rdata (reads only; writes leave rdata unchanged).
REQ-018 Latency: valid sampled edge N, Mem_req high N+1; ack at edge M -> done high M+1; minimum 2 cycles per transaction, next grant no earlier than done cycle.
REQ-019 Requester holds valid and fields until done; valid sampled high in the done cycle is a new request.
REQ-020 Valid dropped before grant is discarded; valid dropped after grant SHALL NOT abort the transaction.
REQ-021 Mem_ack in IDLE SHALL be ignored; I_done and D_done SHALL never be high together.
REQ-022 Mem_req SHALL be registered; no combinational path from any input to Mem_* outputs.

Reset
REQ-023 Reset_n low: state IDLE, Mem_req=0, Mem_we=0, Mem_be=0, Mem_addr=0, Mem_wdata=0, I_done=0, D_done=0, I_rdata=0, D_rdata=0, Err=0, starve count 0, watchdog 0.
REQ-024 Reset mid-transaction drops Mem_req immediately (asynchronously); no done is generated for the aborted transaction.

Configuration
REQ-025 MEM_ARB_TIMEOUT_EN defined: watchdog counts BUSY cycles without Mem_ack; at TIMEOUT_CYCLES, Mem_req->0, state->IDLE, winner's done=1, rdata=32'hDEADBEEF, Err=1 for one cycle.
REQ-026 MEM_ARB_TIMEOUT_EN undefined: no watchdog logic, BUSY waits indefinitely, Err tied 0.

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold the state enum, the STARVE_LIMIT and TIMEOUT_CYCLES defaults, and the 32'hDEADBEEF constant.
REQ-028 One sub-module mem_arb_watchdog (cycle counter, clear/expire), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-029 I_valid, I_addr=0x100, ack 1 cycle after Mem_req, Mem_rdata=0x00000013 -> Mem_addr=0x100, Mem_we=0, I_done one cycle, I_rdata=0x00000013.
REQ-030 I_valid and D_valid together, D write addr=0x2000, be=4'b0011, wdata=0xAABBCCDD -> D served first with Mem_we=1, Mem_be=4'b0011; I served next.
REQ-031 I_valid held, D_valid re-asserted every done, STARVE_LIMIT=4 -> exactly 4 D grants, then an I grant, then the count restarts.
REQ-032 Reset_n pulled low while Mem_req=1 and ack pending -> Mem_req=0 within the same cycle, no done; first request after release is served normally.
REQ-033 With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, D read never acked -> after 8 BUSY cycles Err=1, D_done=1, D_rdata=0xDEADBEEF, state IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
// Holds the arbiter state encoding, default parameter values and the data word
// that is returned to a requester when its transaction times out.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIBusy = 2'd1,
        StDBusy = 2'd2
    } arb_state_e;

    localparam int unsigned STARVE_LIMIT_DEFAULT   = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
    localparam logic [31:0] TIMEOUT_RDATA          = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for the memory arbiter.
// Counts consecutive cycles in which count_i is high and raises expire_o
// (combinationally) on the TIMEOUT_CYCLES-th such cycle; the count restarts
// whenever count_i drops or the watchdog expires.
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   count_i   a transaction is outstanding and not acknowledged this cycle
//   expire_o  limit reached this cycle
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT  // must be >= 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_i,
    output logic expire_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        expire_o = count_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
        cnt_d    = cnt_q + CntW'(1);
        if (!count_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single shared memory port.
// The data side (D) normally wins over the fetch side (I); after STARVE_LIMIT
// consecutive D grants with I waiting, I is served next. One transaction is
// outstanding at a time and every memory-side output is registered.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts a
// transaction after TIMEOUT_CYCLES unacknowledged busy cycles, returning
// 32'hDEADBEEF and pulsing Err. Without it Err is tied low.
// Ports:
//   Clk, Reset_n                  clock, asynchronous active-low reset
//   I_valid/I_addr                fetch read request
//   I_done/I_rdata                fetch completion pulse and data
//   D_valid/D_we/D_be/D_addr/D_wdata  data request
//   D_done/D_rdata                data completion pulse and load data
//   Mem_req/we/be/addr/wdata      shared memory request (held until ack)
//   Mem_ack/Mem_rdata             memory completion and read data
//   Err                           timeout pulse
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = STARVE_LIMIT_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        I_valid,
    input  logic [31:0] I_addr,
    output logic        I_done,
    output logic [31:0] I_rdata,
    input  logic        D_valid,
    input  logic        D_we,
    input  logic [3:0]  D_be,
    input  logic [31:0] D_addr,
    input  logic [31:0] D_wdata,
    output logic        D_done,
    output logic [31:0] D_rdata,
    output logic        Mem_req,
    output logic        Mem_we,
    output logic [3:0]  Mem_be,
    output logic [31:0] Mem_addr,
    output logic [31:0] Mem_wdata,
    input  logic        Mem_ack,
    input  logic [31:0] Mem_rdata,
    output logic        Err
);

    localparam int unsigned StarveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_e   state_d, state_q;
    logic [StarveW-1:0] starve_d, starve_q;
    logic         mem_req_d, mem_req_q;
    logic         mem_we_d, mem_we_q;
    logic [3:0]   mem_be_d, mem_be_q;
    logic [31:0]  mem_addr_d, mem_addr_q;
    logic [31:0]  mem_wdata_d, mem_wdata_q;
    logic         i_done_d, i_done_q;
    logic         d_done_d, d_done_q;
    logic [31:0]  i_rdata_d, i_rdata_q;
    logic [31:0]  d_rdata_d, d_rdata_q;
    logic         starve_at_limit, grant_d, grant_i;
    logic         wd_expire;

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_d, err_q;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .count_i ((state_q != StIdle) && !Mem_ack),
        .expire_o(wd_expire)
    );

    assign Err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_expire      = 1'b0;
    assign Err            = 1'b0;
`endif

    // D wins ties unless I has already waited through STARVE_LIMIT D grants.
    assign starve_at_limit = (starve_q == StarveW'(STARVE_LIMIT));
    assign grant_d = (state_q == StIdle) && D_valid && !(I_valid && starve_at_limit);
    assign grant_i = (state_q == StIdle) && I_valid && !grant_d;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        err_d       = 1'b0;
`endif

        starve_d = starve_q;
        if (!I_valid || grant_i) begin
            starve_d = '0;
        end else if (grant_d && !starve_at_limit) begin
            starve_d = starve_q + StarveW'(1);
        end

        case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d     = StDBusy;
                    mem_req_d   = 1'b1;
                    mem_we_d    = D_we;
                    mem_be_d    = D_be;
                    mem_addr_d  = D_addr;
                    mem_wdata_d = D_wdata;
                end else if (grant_i) begin
                    state_d     = StIBusy;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = I_addr;
                    mem_wdata_d = '0;
                end
            end
            StIBusy: begin
                if (Mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    i_done_d  = 1'b1;
                    i_rdata_d = Mem_rdata;
                end else if (wd_expire) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    i_done_d  = 1'b1;
                    i_rdata_d = TIMEOUT_RDATA;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d     = 1'b1;
`endif
                end
            end
            StDBusy: begin
                if (Mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    // Stores complete without touching the load data.
                    if (!mem_we_q) begin
                        d_rdata_d = Mem_rdata;
                    end
                end else if (wd_expire) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    d_rdata_d = TIMEOUT_RDATA;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_d     = 1'b1;
`endif
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            err_q       <= err_d;
`endif
        end
    end

    assign Mem_req   = mem_req_q;
    assign Mem_we    = mem_we_q;
    assign Mem_be    = mem_be_q;
    assign Mem_addr  = mem_addr_q;
    assign Mem_wdata = mem_wdata_q;
    assign I_done    = i_done_q;
    assign D_done    = d_done_q;
    assign I_rdata   = i_rdata_q;
    assign D_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change 1 ns after a
// rising edge; outputs are checked at the same point.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        I_valid = 1'b0;
    logic [31:0] I_addr = '0;
    logic        I_done;
    logic [31:0] I_rdata;
    logic        D_valid = 1'b0;
    logic        D_we = 1'b0;
    logic [3:0]  D_be = '0;
    logic [31:0] D_addr = '0;
    logic [31:0] D_wdata = '0;
    logic        D_done;
    logic [31:0] D_rdata;
    logic        Mem_req;
    logic        Mem_we;
    logic [3:0]  Mem_be;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_wdata;
    logic        Mem_ack = 1'b0;
    logic [31:0] Mem_rdata = '0;
    logic        Err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 Clk = ~Clk;

    mem_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .I_valid  (I_valid),
        .I_addr   (I_addr),
        .I_done   (I_done),
        .I_rdata  (I_rdata),
        .D_valid  (D_valid),
        .D_we     (D_we),
        .D_be     (D_be),
        .D_addr   (D_addr),
        .D_wdata  (D_wdata),
        .D_done   (D_done),
        .D_rdata  (D_rdata),
        .Mem_req  (Mem_req),
        .Mem_we   (Mem_we),
        .Mem_be   (Mem_be),
        .Mem_addr (Mem_addr),
        .Mem_wdata(Mem_wdata),
        .Mem_ack  (Mem_ack),
        .Mem_rdata(Mem_rdata),
        .Err      (Err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expected winner per grant under a held I request: D x4, I, D.
    logic        exp_is_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset state
        #12;
        check("rst_mem_req", {31'd0, Mem_req}, 32'd0);
        check("rst_mem_addr", Mem_addr, 32'd0);
        check("rst_mem_be", {28'd0, Mem_be}, 32'd0);
        check("rst_dones", {30'd0, I_done, D_done}, 32'd0);
        check("rst_rdata", I_rdata | D_rdata, 32'd0);
        check("rst_err", {31'd0, Err}, 32'd0);
        Reset_n = 1'b1;
        tick();

        // Single fetch read
        I_valid = 1'b1;
        I_addr  = 32'h100;
        tick();
        check("i_req", {31'd0, Mem_req}, 32'd1);
        check("i_addr", Mem_addr, 32'h100);
        check("i_we", {31'd0, Mem_we}, 32'd0);
        check("i_be", {28'd0, Mem_be}, 32'hF);
        Mem_ack   = 1'b1;
        Mem_rdata = 32'h13;
        tick();
        check("i_done", {30'd0, I_done, D_done}, 32'b10);
        check("i_rdata", I_rdata, 32'h13);
        check("i_req_drop", {31'd0, Mem_req}, 32'd0);
        Mem_ack = 1'b0;
        I_valid = 1'b0;
        tick();
        check("i_done_pulse", {31'd0, I_done}, 32'd0);

        // Simultaneous requests: D write first, then I
        I_valid = 1'b1;
        I_addr  = 32'h300;
        D_valid = 1'b1;
        D_we    = 1'b1;
        D_be    = 4'b0011;
        D_addr  = 32'h2000;
        D_wdata = 32'hAABBCCDD;
        tick();
        check("dw_req", {31'd0, Mem_req}, 32'd1);
        check("dw_addr", Mem_addr, 32'h2000);
        check("dw_we", {31'd0, Mem_we}, 32'd1);
        check("dw_be", {28'd0, Mem_be}, 32'b0011);
        check("dw_wdata", Mem_wdata, 32'hAABBCCDD);
        tick();
        check("dw_hold_req", {31'd0, Mem_req}, 32'd1);
        check("dw_hold_addr", Mem_addr, 32'h2000);
        Mem_ack   = 1'b1;
        Mem_rdata = 32'h55555555;
        tick();
        check("dw_done", {30'd0, I_done, D_done}, 32'b01);
        check("dw_rdata_kept", D_rdata, 32'd0);
        Mem_ack = 1'b0;
        D_valid = 1'b0;
        D_we    = 1'b0;
        tick();
        check("i2_req", {31'd0, Mem_req}, 32'd1);
        check("i2_addr", Mem_addr, 32'h300);
        check("i2_we_be", {27'd0, Mem_we, Mem_be}, 32'h0F);
        check("i2_wdata", Mem_wdata, 32'd0);
        Mem_ack   = 1'b1;
        Mem_rdata = 32'h77;
        tick();
        check("i2_done", {30'd0, I_done, D_done}, 32'b10);
        check("i2_rdata", I_rdata, 32'h77);
        Mem_ack = 1'b0;
        I_valid = 1'b0;
        tick();

        // Ack while idle is ignored
        Mem_ack   = 1'b1;
        Mem_rdata = 32'h99;
        tick();
        Mem_ack = 1'b0;
        tick();
        check("idle_ack_done", {30'd0, I_done, D_done}, 32'd0);
        check("idle_ack_req", {31'd0, Mem_req}, 32'd0);
        check("idle_ack_rdata", I_rdata, 32'h77);

        // Starvation: I held, D re-requested at every done
        I_valid = 1'b1;
        I_addr  = 32'h400;
        D_valid = 1'b1;
        D_be    = 4'hF;
        D_addr  = 32'h5000;
        tick();
        for (int g = 0; g < 6; g++) begin
            check($sformatf("starve_req%0d", g), {31'd0, Mem_req}, 32'd1);
            check($sformatf("starve_addr%0d", g), Mem_addr,
                  exp_is_i[g] ? 32'h400 : 32'h5000 + 32'(g * 16));
            Mem_ack   = 1'b1;
            Mem_rdata = 32'hC000 + 32'(g);
            tick();
            check($sformatf("starve_done%0d", g), {30'd0, I_done, D_done},
                  exp_is_i[g] ? 32'b10 : 32'b01);
            Mem_ack = 1'b0;
            D_addr  = 32'h5000 + 32'((g + 1) * 16);
            if (g == 5) begin
                I_valid = 1'b0;
                D_valid = 1'b0;
            end
            tick();
        end
        check("starve_d_rdata", D_rdata, 32'hC005);
        check("starve_i_rdata", I_rdata, 32'hC004);

        // Reset while a transaction is outstanding
        D_valid = 1'b1;
        D_addr  = 32'h6000;
        tick();
        check("rst_mid_req", {31'd0, Mem_req}, 32'd1);
        #3;
        Reset_n = 1'b0;
        #1;
        check("rst_async_req", {31'd0, Mem_req}, 32'd0);
        D_valid = 1'b0;
        Mem_ack = 1'b1;
        tick();
        check("rst_hold_done", {30'd0, I_done, D_done}, 32'd0);
        check("rst_hold_addr", Mem_addr, 32'd0);
        #3;
        Reset_n = 1'b1;
        tick();
        check("rst_rel_done", {30'd0, I_done, D_done}, 32'd0);
        Mem_ack = 1'b0;
        I_valid = 1'b1;
        I_addr  = 32'h700;
        tick();
        check("post_rst_req", {31'd0, Mem_req}, 32'd1);
        check("post_rst_addr", Mem_addr, 32'h700);
        Mem_ack   = 1'b1;
        Mem_rdata = 32'h1234;
        tick();
        check("post_rst_done", {30'd0, I_done, D_done}, 32'b10);
        check("post_rst_rdata", I_rdata, 32'h1234);
        Mem_ack = 1'b0;
        I_valid = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Unacknowledged D read times out after 8 busy cycles
        D_valid = 1'b1;
        D_we    = 1'b0;
        D_addr  = 32'h8000;
        tick();
        for (int c = 1; c < 8; c++) begin
            check($sformatf("to_busy%0d", c), {30'd0, Mem_req, Err}, 32'b10);
            tick();
        end
        check("to_busy8", {30'd0, Mem_req, Err}, 32'b10);
        tick();
        check("to_err", {31'd0, Err}, 32'd1);
        check("to_done", {30'd0, I_done, D_done}, 32'b01);
        check("to_rdata", D_rdata, 32'hDEADBEEF);
        check("to_req", {31'd0, Mem_req}, 32'd0);
        D_valid = 1'b0;
        tick();
        check("to_err_pulse", {31'd0, Err}, 32'd0);
`else
        check("err_tied", {31'd0, Err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
